// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped stream port.
// Holds the word width, the register offsets, the STATUS bit layout and the default window base.
package mmio_pkg;

  localparam int WORD_W = 17;
  localparam int CNT_W  = 5;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_BASE = 17'h1FFFC;

  typedef enum logic [1:0] {
    REG_TX_DATA = 2'd0,
    REG_RX_DATA = 2'd1,
    REG_RX_POP  = 2'd2,
    REG_STATUS  = 2'd3
  } reg_off_e;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_UDF     = 5;
  localparam int ST_TX_CNT_LSB = 6;
  localparam int ST_RX_CNT_LSB = 11;

  function automatic word_t pack_status(
    input logic             tx_full,
    input logic             tx_empty,
    input logic             rx_full,
    input logic             rx_empty,
    input logic             tx_ovf,
    input logic             rx_udf,
    input logic [CNT_W-1:0] tx_cnt,
    input logic [CNT_W-1:0] rx_cnt
  );
    word_t s;
    s                                  = '0;
    s[ST_TX_FULL]                      = tx_full;
    s[ST_TX_EMPTY]                     = tx_empty;
    s[ST_RX_FULL]                      = rx_full;
    s[ST_RX_EMPTY]                     = rx_empty;
    s[ST_TX_OVF]                       = tx_ovf;
    s[ST_RX_UDF]                       = rx_udf;
    s[ST_TX_CNT_LSB +: CNT_W]          = tx_cnt;
    s[ST_RX_CNT_LSB +: CNT_W]          = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_stream_port_if.sv
// Processor data-memory bus plus the TX/RX valid/ready streams of the stream port.
// The port itself uses the slave view; whatever drives the bus and streams uses master.
interface mmio_stream_port_if;
  import mmio_pkg::*;

  logic  MemWrite;
  word_t DataAdr;
  word_t WriteData;
  word_t ReadData;
  logic  hit;

  word_t tx_data;
  logic  tx_valid;
  logic  tx_ready;

  word_t rx_data;
  logic  rx_valid;
  logic  rx_ready;

  modport slave (
    input  MemWrite, DataAdr, WriteData, tx_ready, rx_data, rx_valid,
    output ReadData, hit, tx_data, tx_valid, rx_ready
  );

  modport master (
    output MemWrite, DataAdr, WriteData, tx_ready, rx_data, rx_valid,
    input  ReadData, hit, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock fall-through FIFO; push/pop are qualified internally by full/empty
// as seen before the edge, and the head reads as zero while empty.
module sync_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; dout is forced to zero while empty so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_stream_port.sv
// Memory-mapped responder exposing a TX FIFO (processor stores, sink drains) and an
// RX FIFO (source fills, processor loads and pops) through a 4-word window.
module mmio_stream_port
  import mmio_pkg::*;
#(
  parameter word_t BASE  = DEFAULT_BASE,
  parameter int    DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  mmio_stream_port_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  reg_off_e      off;
  logic          wr;
  logic          tx_push;
  logic          rx_pop;
  logic          st_wr;

  logic          tx_full, tx_empty;
  logic          rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  word_t         rx_head;
  logic          tx_ovf, rx_udf;

  assign off     = reg_off_e'(bus.DataAdr[1:0]);
  assign bus.hit = (bus.DataAdr[WORD_W-1:2] == BASE[WORD_W-1:2]);
  assign wr      = bus.MemWrite && bus.hit;
  assign tx_push = wr && (off == REG_TX_DATA);
  assign rx_pop  = wr && (off == REG_RX_POP);
  assign st_wr   = wr && (off == REG_STATUS);

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (bus.WriteData),
    .pop   (bus.tx_ready),
    .dout  (bus.tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.rx_valid),
    .din   (bus.rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;

  // Sticky error flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_push && tx_full)                      tx_ovf <= 1'b1;
      else if (st_wr && bus.WriteData[ST_TX_OVF])  tx_ovf <= 1'b0;
      if (rx_pop && rx_empty)                      rx_udf <= 1'b1;
      else if (st_wr && bus.WriteData[ST_RX_UDF])  rx_udf <= 1'b0;
    end
  end

  // NOTE: the output is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    bus.ReadData = '0;
    if (bus.hit) begin
      case (off)
        REG_RX_DATA: bus.ReadData = rx_head;
        REG_STATUS:  bus.ReadData = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                                tx_ovf, rx_udf,
                                                CNT_W'(tx_count), CNT_W'(rx_count));
        default:     bus.ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Self-checking bench for mmio_stream_port: directed steps from the test plan followed by
// a randomized phase, all compared against a queue-based model of the register map.
module tb_mmio_stream_port;
  import mmio_pkg::*;

  localparam word_t BASE  = DEFAULT_BASE;
  localparam int    DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_stream_port_if bus ();

  mmio_stream_port #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    n_cmp = 0;
  int    n_mis = 0;
  word_t tx_q[$];
  word_t rx_q[$];
  bit    m_ovf;
  bit    m_udf;

  function automatic word_t adr(input int off);
    word_t a;
    a      = BASE;
    a[1:0] = off[1:0];
    return a;
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t m_status();
    word_t s;
    s        = '0;
    s[0]     = (tx_q.size() == DEPTH);
    s[1]     = (tx_q.size() == 0);
    s[2]     = (rx_q.size() == DEPTH);
    s[3]     = (rx_q.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_udf;
    s[10:6]  = 5'(tx_q.size());
    s[15:11] = 5'(rx_q.size());
    return s;
  endfunction

  function automatic word_t m_read(input word_t a);
    if (a[16:2] != BASE[16:2]) return '0;
    case (a[1:0])
      2'd1:    return (rx_q.size() != 0) ? rx_q[0] : '0;
      2'd3:    return m_status();
      default: return '0;
    endcase
  endfunction

  // Compare every observable output against the model for the current inputs.
  task automatic check_all(input string tag);
    #1;
    check({tag, ".hit"},  word_t'(bus.hit), word_t'(bus.DataAdr[16:2] == BASE[16:2]));
    check({tag, ".rd"},   bus.ReadData, m_read(bus.DataAdr));
    check({tag, ".txv"},  word_t'(bus.tx_valid), word_t'(tx_q.size() != 0));
    check({tag, ".txd"},  bus.tx_data, (tx_q.size() != 0) ? tx_q[0] : '0);
    check({tag, ".rxr"},  word_t'(bus.rx_ready), word_t'(rx_q.size() < DEPTH));
  endtask

  // Advance the model by one rising edge using the inputs currently driven, then wait to the next falling edge.
  task automatic tick();
    bit       wr;
    bit [1:0] off;
    int       tx_n;
    int       rx_n;
    if (!reset) begin
      tx_n = tx_q.size();
      rx_n = rx_q.size();
      wr   = bus.MemWrite && (bus.DataAdr[16:2] == BASE[16:2]);
      off  = bus.DataAdr[1:0];
      if (wr && off == 2'd3) begin
        if (bus.WriteData[4]) m_ovf = 1'b0;
        if (bus.WriteData[5]) m_udf = 1'b0;
      end
      if (bus.tx_ready && tx_n > 0) void'(tx_q.pop_front());
      if (wr && off == 2'd0) begin
        if (tx_n < DEPTH) tx_q.push_back(bus.WriteData);
        else              m_ovf = 1'b1;
      end
      if (wr && off == 2'd2) begin
        if (rx_n > 0) void'(rx_q.pop_front());
        else          m_udf = 1'b1;
      end
      if (bus.rx_valid && rx_n < DEPTH) rx_q.push_back(bus.rx_data);
    end
    @(negedge clk);
  endtask

  task automatic store(input string tag, input int off, input word_t data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = adr(off);
    bus.WriteData = data;
    check_all(tag);
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic load(input string tag, input int off);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = adr(off);
    check_all(tag);
  endtask

  initial begin
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    m_ovf         = 1'b0;
    m_udf         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_all("rst_a0");
    check("rst_hit", word_t'(bus.hit), 17'd0);
    check("rst_rd0", bus.ReadData, 17'd0);
    load("rst_st", 3);
    check("rst_status", bus.ReadData, 17'h0000A);
    check("rst_txv", word_t'(bus.tx_valid), 17'd0);
    check("rst_rxr", word_t'(bus.rx_ready), 17'd1);
    check("rst_txd", bus.tx_data, 17'd0);

    // Two TX words held, then drained on consecutive cycles
    store("tx_w0", 0, 17'h1ABCD);
    store("tx_w1", 0, 17'h00001);
    load("tx_st", 3);
    check("tx_cnt2", word_t'(bus.ReadData[10:6]), 17'd2);
    bus.tx_ready = 1'b1;
    check_all("tx_drain0");
    check("tx_head0", bus.tx_data, 17'h1ABCD);
    tick();
    check_all("tx_drain1");
    check("tx_head1", bus.tx_data, 17'h00001);
    tick();
    check_all("tx_drain2");
    check("tx_empty", word_t'(bus.tx_valid), 17'd0);
    bus.tx_ready = 1'b0;

    // Overflow: 17 stores into a 16-deep TX
    for (int i = 0; i < 17; i++) store("tx_fill", 0, word_t'($urandom));
    load("ovf_st", 3);
    check("ovf_full", word_t'(bus.ReadData[0]), 17'd1);
    check("ovf_flag", word_t'(bus.ReadData[4]), 17'd1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_all("ovf_drain");
      tick();
    end
    check_all("ovf_done");
    check("ovf_no17", word_t'(bus.tx_valid), 17'd0);
    bus.tx_ready = 1'b0;
    store("ovf_w1c", 3, 17'h00010);
    load("ovf_clr", 3);
    check("ovf_cleared", word_t'(bus.ReadData[4]), 17'd0);

    // RX fill to full, then one pop
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rx_data = word_t'(i);
      check_all("rx_fill");
      tick();
    end
    bus.rx_valid = 1'b0;
    load("rx_full", 1);
    check("rx_rdy0", word_t'(bus.rx_ready), 17'd0);
    check("rx_head0", bus.ReadData, 17'd0);
    store("rx_pop", 2, 17'd0);
    load("rx_after", 1);
    check("rx_head1", bus.ReadData, 17'd1);
    check("rx_rdy1", word_t'(bus.rx_ready), 17'd1);

    // Simultaneous push and pop with 3 entries, then underflow
    for (int i = 0; i < 12; i++) store("rx_pop12", 2, word_t'($urandom));
    bus.rx_valid = 1'b1;
    bus.rx_data  = word_t'($urandom);
    store("rx_pushpop", 2, 17'd0);
    bus.rx_valid = 1'b0;
    load("rx_pp_st", 3);
    check("rx_cnt3", word_t'(bus.ReadData[15:11]), 17'd3);
    for (int i = 0; i < 3; i++) store("rx_pop3", 2, 17'd0);
    store("rx_udf_pop", 2, 17'd0);
    load("udf_st", 3);
    check("udf_flag", word_t'(bus.ReadData[5]), 17'd1);
    load("udf_rd", 1);
    check("udf_rd0", bus.ReadData, 17'd0);
    store("udf_w1c", 3, 17'h00020);
    load("udf_clr", 3);
    check("udf_cleared", word_t'(bus.ReadData[5]), 17'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.MemWrite  = ($urandom_range(0, 1) == 1);
      bus.DataAdr   = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : adr(int'($urandom_range(0, 3)));
      bus.WriteData = word_t'($urandom);
      bus.tx_ready  = ($urandom_range(0, 2) == 0);
      bus.rx_valid  = ($urandom_range(0, 1) == 1);
      bus.rx_data   = word_t'($urandom);
      check_all("rnd");
      tick();
    end
    bus.MemWrite = 1'b0;
    bus.rx_valid = 1'b0;

    // Reset in the middle of a TX drain
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load("pre_drain", 3);
      tick();
    end
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) store("rst_fill", 0, word_t'($urandom));
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load("rst_drain", 3);
      tick();
    end
    reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    load("rst_mid", 3);
    check("rst_mid_txv", word_t'(bus.tx_valid), 17'd0);
    tick();
    reset = 1'b0;
    load("rst_post", 3);
    check("rst_post_st", bus.ReadData, 17'h0000A);
    check("rst_post_txv", word_t'(bus.tx_valid), 17'd0);
    bus.tx_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
